regfile_access_arbiter: RTL and testbench



---
 rtl/regfile_access_arbiter_pkg.sv | 18 +
 rtl/regfile_access_arbiter_if.sv | 34 +++
 rtl/regfile_access_arbiter_rr_pick.sv | 27 ++
 rtl/regfile_access_arbiter.sv | 76 +++++++
 tb/tb_regfile_access_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_access_arbiter_pkg.sv
// Shared constants and types for the register-file access arbiter.
package regfile_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int ID_W   = $clog2(N_REQ);

    typedef logic [ID_W-1:0] req_id_t;

    function automatic logic [N_REQ-1:0] id_to_onehot(req_id_t id);
        logic [N_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/regfile_access_arbiter_if.sv
// Bundle of requester, grant, register-file and read-return signals.
interface regfile_access_arbiter_if;
    import regfile_arb_pkg::*;

    // Handshake: a requester raises req[i] with req_we/addr/wdata and holds all of
    // them stable until gnt[i] pulses for one cycle; that cycle is the access. It
    // may drop req early, in which case nothing is served. A read returns its data
    // one cycle after gnt with a single-cycle rvalid tagged by rvalid_id.
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic                    rf_we;
    logic [ADDR_W-1:0]       rf_waddr;
    logic [DATA_W-1:0]       rf_wdata;
    logic [ADDR_W-1:0]       rf_raddr;
    logic [DATA_W-1:0]       rf_rdata;
    logic [DATA_W-1:0]       rdata;
    logic                    rvalid;
    req_id_t                 rvalid_id;

    // master: the requesters together with the register-file core
    modport master (
        output req, req_we, req_addr, req_wdata, rf_rdata,
        input  gnt, rf_we, rf_waddr, rf_wdata, rf_raddr, rdata, rvalid, rvalid_id
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata, rf_rdata,
        output gnt, rf_we, rf_waddr, rf_wdata, rf_raddr, rdata, rvalid, rvalid_id
    );

endinterface

// File: rtl/regfile_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr, wrapping.
module rr_pick
    import regfile_arb_pkg::*;
(
    input  logic [N_REQ-1:0] eligible,
    input  req_id_t          ptr,
    output logic             found,
    output req_id_t          winner
);

    req_id_t idx;

    // Walk from the farthest offset down so the nearest eligible index wins last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + req_id_t'(i);
            if (eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing the register file's single write/read port among
// N_REQ requesters; registers the file controls and returns read data with its owner ID.
module regfile_access_arbiter
    import regfile_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_access_arbiter_if.slave  bus,
    output req_id_t                  dbg_ptr
);

    req_id_t           ptr;
    req_id_t           winner;
    req_id_t           rd_id;
    logic              found;
    logic              rd_pend;
    logic [N_REQ-1:0]  eligible;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // The requester granted this cycle still holds req; mask it so it is not served twice.
    assign eligible = bus.req & ~bus.gnt;

    rr_pick u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .found    (found),
        .winner   (winner)
    );

    assign win_we    = bus.req_we[winner];
    assign win_addr  = bus.req_addr[int'(winner) * ADDR_W +: ADDR_W];
    assign win_wdata = bus.req_wdata[int'(winner) * DATA_W +: DATA_W];
    assign dbg_ptr   = ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr           <= '0;
            rd_pend       <= 1'b0;
            rd_id         <= '0;
            bus.gnt       <= '0;
            bus.rf_we     <= 1'b0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.rf_raddr  <= '0;
            bus.rdata     <= '0;
            bus.rvalid    <= 1'b0;
            bus.rvalid_id <= '0;
        end else begin
            bus.gnt    <= '0;
            bus.rf_we  <= 1'b0;
            rd_pend    <= 1'b0;
            bus.rvalid <= rd_pend;
            // rf_raddr was presented during the grant cycle, so rf_rdata is valid now.
            if (rd_pend) begin
                bus.rdata     <= bus.rf_rdata;
                bus.rvalid_id <= rd_id;
            end
            if (found) begin
                bus.gnt <= id_to_onehot(winner);
                ptr     <= winner + req_id_t'(1);
                if (win_we) begin
                    bus.rf_we    <= 1'b1;
                    bus.rf_waddr <= win_addr;
                    bus.rf_wdata <= win_wdata;
                end else begin
                    bus.rf_raddr <= win_addr;
                    rd_pend      <= 1'b1;
                    rd_id        <= winner;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_regfile_access_arbiter;
    import regfile_arb_pkg::*;

    logic    clk;
    logic    rst_n;
    req_id_t dbg_ptr;
    int      total;
    int      bad;

    regfile_access_arbiter_if bus();

    regfile_access_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .dbg_ptr (dbg_ptr)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- register file stand-in ----------------
    logic [DATA_W-1:0] rf_mem [32];
    bit                rf_ready = 1'b0;

    function automatic logic [DATA_W-1:0] init_word(int i);
        return (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (!rf_ready) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_word(i);
            rf_ready <= 1'b1;
        end else if (bus.rf_we) begin
            rf_mem[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    assign bus.rf_rdata = rf_mem[bus.rf_raddr];

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_mem [32];
    bit                m_ready = 1'b0;
    int                m_ptr;
    bit                m_pend;
    int                m_pend_id;
    logic [N_REQ-1:0]  exp_gnt;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_waddr;
    logic [DATA_W-1:0] exp_wdata;
    logic [ADDR_W-1:0] exp_raddr;
    logic              exp_rvalid;
    int                exp_rid;
    logic [DATA_W-1:0] exp_rdata;

    always @(posedge clk) begin
        logic [N_REQ-1:0] elig;
        int               w;
        int               idx;
        bit               hit;
        if (!m_ready) begin
            for (int i = 0; i < 32; i++) m_mem[i] = init_word(i);
            m_ready = 1'b1;
        end else if (exp_we) begin
            m_mem[exp_waddr] = exp_wdata;
        end
        if (!rst_n) begin
            m_ptr = 0; m_pend = 1'b0; m_pend_id = 0;
            exp_gnt = '0; exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
            exp_raddr = '0; exp_rvalid = 1'b0; exp_rid = 0; exp_rdata = '0;
        end else begin
            exp_rvalid = m_pend;
            if (m_pend) begin
                exp_rdata = m_mem[exp_raddr];
                exp_rid   = m_pend_id;
            end
            m_pend  = 1'b0;
            elig    = bus.req & ~exp_gnt;
            exp_gnt = '0;
            exp_we  = 1'b0;
            hit     = 1'b0;
            w       = 0;
            for (int k = 0; k < N_REQ; k++) begin
                idx = (m_ptr + k) % N_REQ;
                if (!hit && elig[idx]) begin
                    hit = 1'b1;
                    w   = idx;
                end
            end
            if (hit) begin
                exp_gnt[w] = 1'b1;
                m_ptr      = (w + 1) % N_REQ;
                if (bus.req_we[w]) begin
                    exp_we    = 1'b1;
                    exp_waddr = bus.req_addr[w*ADDR_W +: ADDR_W];
                    exp_wdata = bus.req_wdata[w*DATA_W +: DATA_W];
                end else begin
                    exp_raddr = bus.req_addr[w*ADDR_W +: ADDR_W];
                    m_pend    = 1'b1;
                    m_pend_id = w;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("gnt",      DATA_W'(bus.gnt),      DATA_W'(exp_gnt));
        check("rf_we",    DATA_W'(bus.rf_we),    DATA_W'(exp_we));
        check("rf_waddr", DATA_W'(bus.rf_waddr), DATA_W'(exp_waddr));
        check("rf_wdata", bus.rf_wdata,          exp_wdata);
        check("rf_raddr", DATA_W'(bus.rf_raddr), DATA_W'(exp_raddr));
        check("rvalid",   DATA_W'(bus.rvalid),   DATA_W'(exp_rvalid));
        if (exp_rvalid) begin
            check("rvalid_id", DATA_W'(bus.rvalid_id), DATA_W'(exp_rid));
            check("rdata",     bus.rdata,              exp_rdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(int i, bit en, bit we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        bus.req[i]                       = en;
        bus.req_we[i]                    = we;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic new_req(int i);
        set_req(i, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // reset held two cycles with every requester asking
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b0, '0, '0);
        tick();
        tick();
        check("reset_gnt",    DATA_W'(bus.gnt),    0);
        check("reset_rf_we",  DATA_W'(bus.rf_we),  0);
        check("reset_rvalid", DATA_W'(bus.rvalid), 0);
        check("reset_rdata",  bus.rdata,           0);
        rst_n = 1'b1;

        // fairness: all held, grants rotate 0,1,2,3,0,1 with no gap
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_order", DATA_W'(bus.gnt), DATA_W'(1 << (k % 4)));
        end
        bus.req = '0;
        tick();
        tick();

        // write then read of the same address by requester 2
        set_req(2, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        check("wr_gnt",   DATA_W'(bus.gnt),      32'h4);
        check("wr_we",    DATA_W'(bus.rf_we),    1);
        check("wr_addr",  DATA_W'(bus.rf_waddr), 5);
        check("wr_data",  bus.rf_wdata,          32'hDEAD_BEEF);
        set_req(2, 1'b1, 1'b0, 5'd5, '0);
        tick();
        check("rd_masked", DATA_W'(bus.gnt), 0);
        tick();
        check("rd_gnt",   DATA_W'(bus.gnt),      32'h4);
        check("rd_we",    DATA_W'(bus.rf_we),    0);
        check("rd_addr",  DATA_W'(bus.rf_raddr), 5);
        bus.req = '0;
        tick();
        check("rd_rvalid", DATA_W'(bus.rvalid),    1);
        check("rd_id",     DATA_W'(bus.rvalid_id), 2);
        check("rd_data",   bus.rdata,              32'hDEAD_BEEF);
        tick();

        // lone requester is granted every other cycle
        set_req(1, 1'b1, 1'b0, 5'd9, '0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("lone_gnt", DATA_W'(bus.gnt), (k % 2 == 0) ? 32'h2 : 32'h0);
        end
        bus.req = '0;
        tick();

        // wrap-around from pointer 3
        set_req(2, 1'b1, 1'b0, 5'd3, '0);
        tick();
        check("wrap_setup", DATA_W'(bus.gnt), 32'h4);
        bus.req = '0;
        tick();
        check("wrap_ptr", DATA_W'(dbg_ptr), 3);
        set_req(0, 1'b1, 1'b0, 5'd1, '0);
        set_req(1, 1'b1, 1'b0, 5'd2, '0);
        tick();
        check("wrap_first", DATA_W'(bus.gnt), 32'h1);
        bus.req[0] = 1'b0;
        tick();
        check("wrap_second", DATA_W'(bus.gnt), 32'h2);
        bus.req = '0;
        tick();

        // reset arriving while a read is in flight
        set_req(3, 1'b1, 1'b0, 5'd7, '0);
        tick();
        check("midrd_gnt", DATA_W'(bus.gnt), 32'h8);
        bus.req = '0;
        rst_n   = 1'b0;
        tick();
        check("midrd_rvalid", DATA_W'(bus.rvalid), 0);
        check("midrd_rdata",  bus.rdata,           0);
        check("midrd_gnt0",   DATA_W'(bus.gnt),    0);
        rst_n = 1'b1;

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req[i] && bus.gnt[i]) begin
                    if ($urandom_range(0, 1) == 1) new_req(i);
                    else bus.req[i] = 1'b0;
                end else if (bus.req[i]) begin
                    if ($urandom_range(0, 19) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(i);
                end
            end
        end
        bus.req = '0;
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
